// File: rtl/adder_pipe_nbit_if.sv
// adder_pipe_nbit_if
//   Stream bundle for the pipelined adder: one operand stream in, one
//   result stream out, both valid/ready.
//   Signals:
//     in_valid / in_ready   operand beat handshake
//     in_a, in_b            operands (WIDTH bits)
//     in_cin                carry-in for add; ignored for subtract
//     in_sub                1 = A-B, 0 = A+B+cin
//     out_valid / out_ready result beat handshake
//     out_sum               result (WIDTH bits)
//     out_cout              carry out of MSB (subtract: 1 = no borrow)
//     out_ovf               two's-complement signed overflow
//   Modports: slave = the adder, master = the producer/consumer side.
interface adder_pipe_nbit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/adder_pipe_nbit.sv
// adder_pipe_nbit
//   Pipelined WIDTH-bit add/subtract. The carry chain is cut into STAGES
//   equal segments of SEG bits; each stage ripples one segment through a
//   chain of adder_1bit cells and registers its carry for the next stage.
//   Operands are captured in an input rank, so a beat accepted at edge N
//   shows its result from edge N+STAGES. Upper operand bits travel along
//   (skew registers) and finished lower sum segments are carried forward so
//   all segments leave together.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset; clears every valid bit and all
//           datapath state, and forces outputs and in_ready low while high
//     bus   adder_pipe_nbit_if.slave stream bundle (WIDTH must match)
//   Flow control is a single global stall: when the result beat is held by
//   the consumer, every rank holds and in_ready drops.

// adder_1bit
//   One full-adder cell. IMPL_TYPE picks the gate form; both forms are
//   functionally identical.
//   Ports: a, b, cin -> sum, cout
module adder_1bit #(
  parameter int IMPL_TYPE = 0
) (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  generate
    case (IMPL_TYPE)
      1: begin : g_prop_gen
        logic p_s;
        logic g_s;
        assign p_s  = a ^ b;
        assign g_s  = a & b;
        assign sum  = p_s ^ cin;
        assign cout = g_s | (p_s & cin);
      end
      default: begin : g_majority
        assign sum  = a ^ b ^ cin;
        assign cout = (a & b) | (a & cin) | (b & cin);
      end
    endcase
  endgenerate
endmodule

module adder_pipe_nbit #(
  parameter int WIDTH     = 32,
  parameter int STAGES    = 4,
  parameter int IMPL_TYPE = 0
) (
  input  logic             clk,
  input  logic             rst,
  adder_pipe_nbit_if.slave bus
);
  // Guarded divisor so an illegal STAGES reports through the check below
  // instead of a divide-by-zero.
  localparam int STAGES_SAFE = (STAGES < 1) ? 1 : STAGES;
  localparam int SEG         = WIDTH / STAGES_SAFE;

  generate
    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES_SAFE) != 0)) begin : g_bad_stages
      $error("adder_pipe_nbit: STAGES must be in 1..WIDTH and divide WIDTH");
    end
  endgenerate

  // Input rank: operands with the subtract mapping already applied.
  logic             op_vld_q, op_vld_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_cin_q, op_cin_d;

  // Per-stage ranks: operand skew, accumulated sum, segment carry.
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cy_q, cy_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic              ovf_q, ovf_d;

  // What each stage consumes this cycle.
  logic [WIDTH-1:0]  st_a_s   [STAGES];
  logic [WIDTH-1:0]  st_b_s   [STAGES];
  logic [WIDTH-1:0]  st_sum_s [STAGES];
  logic [STAGES-1:0] st_cin_s;
  logic [STAGES-1:0] st_vld_s;

  // Segment adder results.
  logic [STAGES-1:0][SEG-1:0] seg_sum_s;
  logic [STAGES-1:0]          seg_cout_s;
  logic                       last_cmsb_s;   // carry into the MSB cell

  logic enable_s;
  logic accept_s;
  logic out_valid_s;

  // Outputs are the last rank, masked while reset is asserted so they read
  // zero even on the first reset cycle before the flops have cleared.
  assign out_valid_s   = vld_q[STAGES-1] & ~rst;
  assign enable_s      = ~(out_valid_s & ~bus.out_ready);
  assign bus.in_ready  = enable_s & ~rst;
  assign accept_s      = bus.in_valid & enable_s & ~rst;
  assign bus.out_valid = out_valid_s;
  assign bus.out_sum   = rst ? {WIDTH{1'b0}} : sum_q[STAGES-1];
  assign bus.out_cout  = cy_q[STAGES-1] & ~rst;
  assign bus.out_ovf   = ovf_q & ~rst;

  // Route each stage's inputs: stage 0 from the input rank, later stages
  // from the rank before them.
  always_comb begin
    st_a_s[0]   = op_a_q;
    st_b_s[0]   = op_b_q;
    st_sum_s[0] = {WIDTH{1'b0}};
    st_cin_s    = {STAGES{1'b0}};
    st_vld_s    = {STAGES{1'b0}};
    st_cin_s[0] = op_cin_q;
    st_vld_s[0] = op_vld_q;
    for (int k = 1; k < STAGES; k++) begin
      st_a_s[k]   = a_q[k-1];
      st_b_s[k]   = b_q[k-1];
      st_sum_s[k] = sum_q[k-1];
      st_cin_s[k] = cy_q[k-1];
      st_vld_s[k] = vld_q[k-1];
    end
  end

  // Segment ripple chains; each bit is its own net so the chain is not one
  // self-referencing vector.
  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      for (genvar j = 0; j < SEG; j++) begin : g_bit
        logic ci_s;
        logic co_s;
        logic s_s;
        if (j == 0) begin : g_first
          assign ci_s = st_cin_s[k];
        end else begin : g_next
          assign ci_s = g_bit[j-1].co_s;
        end
        adder_1bit #(.IMPL_TYPE(IMPL_TYPE)) u_fa (
          .a    (st_a_s[k][k*SEG+j]),
          .b    (st_b_s[k][k*SEG+j]),
          .cin  (ci_s),
          .sum  (s_s),
          .cout (co_s)
        );
        assign seg_sum_s[k][j] = s_s;
      end
      assign seg_cout_s[k] = g_bit[SEG-1].co_s;
      if (k == STAGES - 1) begin : g_last
        assign last_cmsb_s = g_bit[SEG-1].ci_s;
      end
    end
  endgenerate

  // Next-state: every rank advances together or holds together.
  always_comb begin
    op_vld_d = op_vld_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_cin_d = op_cin_q;
    vld_d    = vld_q;
    cy_d     = cy_q;
    ovf_d    = ovf_q;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      sum_d[k] = sum_q[k];
    end
    if (enable_s) begin
      // Subtract is A + ~B + 1; in_cin only matters for add.
      op_vld_d = accept_s;
      op_a_d   = bus.in_a;
      op_b_d   = bus.in_sub ? ~bus.in_b : bus.in_b;
      op_cin_d = bus.in_sub ? 1'b1 : bus.in_cin;
      vld_d    = st_vld_s;
      cy_d     = seg_cout_s;
      ovf_d    = last_cmsb_s ^ seg_cout_s[STAGES-1];
      for (int k = 0; k < STAGES; k++) begin
        a_d[k]   = st_a_s[k];
        b_d[k]   = st_b_s[k];
        sum_d[k] = st_sum_s[k];
        sum_d[k][k*SEG +: SEG] = seg_sum_s[k];
      end
    end else begin
      // Stalled: defaults above keep every rank unchanged.
      ovf_d = ovf_q;
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_vld_q <= 1'b0;
      op_a_q   <= {WIDTH{1'b0}};
      op_b_q   <= {WIDTH{1'b0}};
      op_cin_q <= 1'b0;
      vld_q    <= {STAGES{1'b0}};
      cy_q     <= {STAGES{1'b0}};
      ovf_q    <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= {WIDTH{1'b0}};
        b_q[k]   <= {WIDTH{1'b0}};
        sum_q[k] <= {WIDTH{1'b0}};
      end
    end else begin
      op_vld_q <= op_vld_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_cin_q <= op_cin_d;
      vld_q    <= vld_d;
      cy_q     <= cy_d;
      ovf_q    <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end
endmodule

// File: tb/tb_adder_pipe_nbit.sv
// tb_adder_pipe_nbit
//   Two builds side by side: WIDTH=32/STAGES=4 (main) and WIDTH=32/STAGES=1.
//   A signed/unsigned arithmetic model feeds a per-DUT scoreboard; directed
//   beats also pin exact latency and literal results.
module tb_adder_pipe_nbit;
  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct packed {
    logic        iv;
    logic        ir;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        ov;
    logic        ordy;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } bus_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  localparam longint UTOP = 64'sd4294967296;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  res_t sbq [2][$];
  bit   stall [2];
  res_t hold [2];
  int   npop [2];
  bus_t mon_v;
  bus_t mv;
  res_t e_mon;

  adder_pipe_nbit_if #(.WIDTH(32)) b4 ();
  adder_pipe_nbit_if #(.WIDTH(32)) b1 ();

  adder_pipe_nbit #(.WIDTH(32), .STAGES(4), .IMPL_TYPE(0)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  adder_pipe_nbit #(.WIDTH(32), .STAGES(1), .IMPL_TYPE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result from integer arithmetic: signed range decides overflow,
  // unsigned range decides carry / no-borrow.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    res_t   r;
    longint sa, sb, sres, ua, ub, ures;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (sub) begin
      sres   = sa - sb;
      ures   = ua - ub;
      r.cout = (ua >= ub);
    end else begin
      sres   = sa + sb + longint'(cin);
      ures   = ua + ub + longint'(cin);
      r.cout = (ures >= UTOP);
    end
    r.sum = ures[31:0];
    r.ovf = (sres > SMAX) || (sres < SMIN);
    return r;
  endfunction

  function automatic bus_t snap(input int s);
    bus_t r;
    if (s == 1)
      r = {b1.in_valid, b1.in_ready, b1.in_a, b1.in_b, b1.in_cin, b1.in_sub,
           b1.out_valid, b1.out_ready, b1.out_sum, b1.out_cout, b1.out_ovf};
    else
      r = {b4.in_valid, b4.in_ready, b4.in_a, b4.in_b, b4.in_cin, b4.in_sub,
           b4.out_valid, b4.out_ready, b4.out_sum, b4.out_cout, b4.out_ovf};
    return r;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] r;
    case ($urandom_range(0, 5))
      0: r = 32'h0000_0000;
      1: r = 32'hFFFF_FFFF;
      2: r = 32'h8000_0000;
      3: r = 32'h7FFF_FFFF;
      default: r = $urandom;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_in(input int sel, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic cin, input logic sub);
    if (sel == 1) begin
      b1.in_valid = v; b1.in_a = a; b1.in_b = b; b1.in_cin = cin; b1.in_sub = sub;
    end else begin
      b4.in_valid = v; b4.in_a = a; b4.in_b = b; b4.in_cin = cin; b4.in_sub = sub;
    end
  endtask

  // Present one beat until accepted (bounded); returns 1ns after the accept edge.
  task automatic send(input int sel, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic sub);
    bus_t v;
    int   n;
    n = 0;
    drive_in(sel, 1'b1, a, b, cin, sub);
    do begin
      @(negedge clk);
      v = snap(sel);
      @(posedge clk);
      #1;
      n++;
    end while (!v.ir && n < 50);
    drive_in(sel, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
    if (!v.ir) chk("send_timeout", 64'd1, 64'd0);
  endtask

  // Count edges after the accept edge until out_valid shows, then check it.
  task automatic wait_out(input int sel, input int lat, input res_t exp, input string nm);
    bus_t v;
    int   k;
    k = 0;
    do begin
      @(negedge clk);
      v = snap(sel);
      k++;
    end while (!v.ov && k < 20);
    chk({nm, "_lat"}, 64'(k - 1), 64'(lat));
    chk({nm, "_res"}, 64'({v.sum, v.cout, v.ovf}), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and stall-stability compare for both DUTs.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      mon_v = snap(s);
      if (rst) begin
        sbq[s].delete();
        stall[s] = 1'b0;
      end else begin
        if (stall[s]) begin
          chk("hold_valid", 64'(mon_v.ov), 64'd1);
          chk("hold_result", 64'({mon_v.sum, mon_v.cout, mon_v.ovf}), 64'(hold[s]));
        end
        if (mon_v.ov && mon_v.ordy) begin
          if (sbq[s].size() == 0) begin
            chk("unexpected_out", 64'd1, 64'd0);
          end else begin
            e_mon = sbq[s].pop_front();
            chk("sb_result", 64'({mon_v.sum, mon_v.cout, mon_v.ovf}), 64'(e_mon));
            npop[s]++;
          end
        end
        if (mon_v.iv && mon_v.ir)
          sbq[s].push_back(model(mon_v.a, mon_v.b, mon_v.cin, mon_v.sub));
        stall[s] = mon_v.ov && !mon_v.ordy;
        hold[s]  = {mon_v.sum, mon_v.cout, mon_v.ovf};
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got [8];
    int          idx;
    int          n;
    int          base;
    logic        acc;

    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    b4.out_ready = 1'b1;
    b1.out_ready = 1'b1;
    drive_in(0, 1'b1, $urandom, $urandom, 1'b1, 1'b0);
    drive_in(1, 1'b1, $urandom, $urandom, 1'b1, 1'b0);

    // Model pinned to hand-computed results.
    chk("pin_carry_all", 64'(model(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0)), 64'({32'h0, 1'b1, 1'b0}));
    chk("pin_sub_ovf",   64'(model(32'h8000_0000, 32'h1, 1'b1, 1'b1)), 64'({32'h7FFF_FFFF, 1'b1, 1'b1}));
    chk("pin_sub_borrow", 64'(model(32'h0, 32'h1, 1'b0, 1'b1)), 64'({32'hFFFF_FFFF, 1'b0, 1'b0}));
    chk("pin_add_ovf",   64'(model(32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0)), 64'({32'h8000_0000, 1'b0, 1'b1}));

    // Reset held 3 cycles with live input traffic.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        mv = snap(s);
        chk("rst_out_valid", 64'(mv.ov), 64'd0);
        chk("rst_out_sum", 64'(mv.sum), 64'd0);
        chk("rst_out_cout", 64'(mv.cout), 64'd0);
        chk("rst_out_ovf", 64'(mv.ovf), 64'd0);
        chk("rst_in_ready", 64'(mv.ir), 64'd0);
      end
      @(posedge clk);
      #1;
      drive_in(0, 1'b1, $urandom, $urandom, 1'b1, 1'b0);
      drive_in(1, 1'b1, $urandom, $urandom, 1'b1, 1'b0);
    end
    rst = 1'b0;
    drive_in(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive_in(1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Directed beats, STAGES=4.
    send(0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    wait_out(0, 4, {32'h0, 1'b1, 1'b0}, "carry_all");
    send(0, 32'h8000_0000, 32'h1, 1'b1, 1'b1);
    wait_out(0, 4, {32'h7FFF_FFFF, 1'b1, 1'b1}, "sub_ovf");
    send(0, 32'h0, 32'h1, 1'b0, 1'b1);
    wait_out(0, 4, {32'hFFFF_FFFF, 1'b0, 1'b0}, "sub_borrow");

    // Backpressure: 8 back-to-back beats, consumer stalls cycles 6..8.
    idx = 0;
    n   = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      drive_in(0, idx < 8, 32'(idx), 32'(idx * 16), 1'b0, 1'b0);
      b4.out_ready = !(c >= 6 && c <= 8);
      @(negedge clk);
      if (c >= 6 && c <= 8) chk("bp_in_ready", 64'(b4.in_ready), 64'd0);
      acc = b4.in_valid && b4.in_ready;
      if (b4.out_valid && b4.out_ready) begin
        got[n] = b4.out_sum;
        n++;
      end
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    drive_in(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    b4.out_ready = 1'b1;
    chk("bp_count", 64'(n), 64'd8);
    for (int i = 0; i < 8; i++) chk("bp_sum", 64'(got[i]), 64'(32'(i * 17)));

    // Reset while three beats are in flight.
    for (int i = 0; i < 3; i++) send(0, 32'(i + 1), 32'(i + 2), 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 64'(b4.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(b4.in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(0, 32'd5, 32'd7, 1'b0, 1'b0);
    wait_out(0, 4, {32'd12, 1'b0, 1'b0}, "after_rst");

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      drive_in(0, $urandom_range(0, 3) != 0, pick(), pick(),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      b4.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    drive_in(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    b4.out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("drain4_empty", 64'(sbq[0].size()), 64'd0);

    // STAGES=1 build: latency 1 and full-rate streaming.
    send(1, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0);
    wait_out(1, 1, {32'h8000_0000, 1'b0, 1'b1}, "s1_add_ovf");
    base = npop[1];
    for (int c = 0; c < 16; c++) begin
      drive_in(1, 1'b1, pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      chk("s1_in_ready", 64'(b1.in_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    drive_in(1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("s1_stream_count", 64'(npop[1] - base), 64'd16);
    chk("drain1_empty", 64'(sbq[1].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
